// File: rtl/mdu_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10
    } md_op_t;

    // Multi-cycle ops that occupy the unit and later commit to HI/LO.
    function automatic logic is_arith(input md_op_t op);
        return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
    endfunction

    // Ops that use the divide latency.
    function automatic logic is_div(input md_op_t op);
        return op inside {DIV, DIVU};
    endfunction

    // Accumulating ops that fold the current {HI,LO} into the product.
    function automatic logic is_macc(input md_op_t op);
        return op inside {MADD, MADDU, MSUB, MSUBU};
    endfunction

endpackage

// File: rtl/hilo_md_arith.sv
// Combinational datapath: turns a latched op, its operands and the latched
// {HI,LO} into the value HI/LO should take at commit.
import mdu_pkg::*;

module hilo_md_arith #(
    parameter int WIDTH = 32
) (
    input  md_op_t             op,
    input  logic [WIDTH-1:0]   opA,
    input  logic [WIDTH-1:0]   opB,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] nextHiLo,
    output logic               noWrite
);

    localparam logic [WIDTH-1:0] intMin = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]        divisor;
    logic [WIDTH-1:0]        sDivisor;
    logic [2*WIDTH-1:0]      sProd;
    logic [2*WIDTH-1:0]      uProd;
    logic signed [WIDTH-1:0] sQuot;
    logic signed [WIDTH-1:0] sRem;
    logic [WIDTH-1:0]        uQuot;
    logic [WIDTH-1:0]        uRem;

    // Divisors are steered away from zero and from the INT_MIN/-1 overflow;
    // dividing INT_MIN by 1 already yields quotient INT_MIN, remainder 0.
    always_comb begin
        divisor  = (opB == '0) ? WIDTH'(1) : opB;
        sDivisor = (opA == intMin && opB == '1) ? WIDTH'(1) : divisor;
        sProd    = {{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opB[WIDTH-1]}}, opB};
        uProd    = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
        sQuot    = $signed(opA) / $signed(sDivisor);
        sRem     = $signed(opA) % $signed(sDivisor);
        uQuot    = opA / divisor;
        uRem     = opA % divisor;
        nextHiLo = acc;
        noWrite  = 1'b0;
        case (op)
            MULT:    nextHiLo = sProd;
            MULTU:   nextHiLo = uProd;
            MADD:    nextHiLo = acc + sProd;
            MADDU:   nextHiLo = acc + uProd;
            MSUB:    nextHiLo = acc - sProd;
            MSUBU:   nextHiLo = acc - uProd;
            DIV: begin
                nextHiLo = {sRem, sQuot};
                noWrite  = (opB == '0);
            end
            DIVU: begin
                nextHiLo = {uRem, uQuot};
                noWrite  = (opB == '0);
            end
            default: noWrite = 1'b1;
        endcase
    end

endmodule

// File: rtl/hilo_md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, the latency counter and the
// accept/cancel/commit control; arithmetic lives in hilo_md_arith.
import mdu_pkg::*;

module hilo_md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int HAS_MACC    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    input  logic             rd_hi,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int maxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int cntW      = $clog2(maxCycles + 1);

    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [cntW-1:0]    count;
    md_op_t             opReg;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [2*WIDTH-1:0] accReg;
    logic [2*WIDTH-1:0] nextHiLo;
    logic               noWrite;
    logic               opLegal;
    logic               accept;
    logic               moveOk;

    // With HAS_MACC=0 the accumulate ops fall through as NOPs.
    assign opLegal = is_arith(op) && ((HAS_MACC != 0) || !is_macc(op));
    assign accept  = start && !cancel && !busy && opLegal;
    assign moveOk  = start && !cancel && !busy && (op == MTHI || op == MTLO);
    assign busy    = (count != '0);
    assign result  = rd_hi ? hiReg : loReg;
    assign hi_q    = hiReg;
    assign lo_q    = loReg;

    hilo_md_arith #(.WIDTH(WIDTH)) uArith (
        .op       (opReg),
        .opA      (aReg),
        .opB      (bReg),
        .acc      (accReg),
        .nextHiLo (nextHiLo),
        .noWrite  (noWrite)
    );

    // HI/LO, counter and latched op: cancel beats commit, and nothing new is
    // accepted until the counter has drained.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hiReg  <= '0;
            loReg  <= '0;
            count  <= '0;
            opReg  <= NOP;
            aReg   <= '0;
            bReg   <= '0;
            accReg <= '0;
        end else if (busy) begin
            if (cancel) begin
                count <= '0;
            end else if (count == cntW'(1)) begin
                count <= '0;
                if (!noWrite) begin
                    hiReg <= nextHiLo[2*WIDTH-1:WIDTH];
                    loReg <= nextHiLo[WIDTH-1:0];
                end
            end else begin
                count <= count - cntW'(1);
            end
        end else if (accept) begin
            opReg  <= op;
            aReg   <= src_a;
            bReg   <= src_b;
            accReg <= {hiReg, loReg};
            count  <= is_div(op) ? cntW'(DIV_CYCLES) : cntW'(MULT_CYCLES);
        end else if (moveOk) begin
            if (op == MTHI) hiReg <= src_a;
            else            loReg <= src_a;
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed cases followed by a random
// sequence compared against a plain-arithmetic model of HI/LO.
import mdu_pkg::*;

module tb_hilo_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    md_op_t      op = NOP;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        cancel = 1'b0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    hilo_md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .rd_hi  (rd_hi),
        .busy   (busy),
        .result (result),
        .hi_q   (hi_q),
        .lo_q   (lo_q)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse for a single edge, then return inputs to idle.
    task automatic applyStimulus(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        tick();
        start = 1'b0;
        op    = NOP;
    endtask

    // Architectural result of an op from the instruction's definition.
    function automatic logic [63:0] refResult(input md_op_t o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        int              sa, sb, q, rm;
        longint          sp;
        longint unsigned ua, ub, up;
        logic [63:0]     r;
        sa = a;
        sb = b;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sp = longint'(sa) * longint'(sb);
        up = ua * ub;
        r  = acc;
        case (o)
            MULT:  r = sp;
            MULTU: r = up;
            MADD:  r = acc + sp;
            MADDU: r = acc + up;
            MSUB:  r = acc - sp;
            MSUBU: r = acc - up;
            DIV: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        r = {32'h0, 32'h8000_0000};
                    end else begin
                        q  = sa / sb;
                        rm = sa % sb;
                        r  = {rm, q};
                    end
                end
            end
            DIVU:  if (b != 0) r = {a % b, a / b};
            default: r = acc;
        endcase
        return r;
    endfunction

    // Issue one op, wait out its busy window, then compare with the model.
    task automatic runOp(input string tag, input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        int expCyc;
        applyStimulus(o, a, b);
        if (o == MTHI || o == MTLO) begin
            if (o == MTHI) mHi = a;
            else           mLo = a;
            checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
        end else begin
            expCyc = is_div(o) ? 10 : 5;
            {mHi, mLo} = refResult(o, a, b, {mHi, mLo});
            cyc = 0;
            while (busy && cyc < 40) begin
                cyc++;
                tick();
            end
            checkOutput({tag, "_cycles"}, cyc, expCyc);
        end
        checkOutput({tag, "_hi"}, hi_q, mHi);
        checkOutput({tag, "_lo"}, lo_q, mLo);
    endtask

    initial begin
        md_op_t      opList [10] = '{MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO};
        md_op_t      rop;
        logic [31:0] ra, rb;

        // Reset state
        tick();
        tick();
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_hi", hi_q, 32'h0);
        checkOutput("rst_lo", lo_q, 32'h0);
        reset = 1'b1;
        tick();

        // Multiply and divide basics
        runOp("mult", MULT, 32'hFFFF_FFFD, 32'd5);
        checkOutput("mult_hiK", hi_q, 32'hFFFF_FFFF);
        checkOutput("mult_loK", lo_q, 32'hFFFF_FFF1);
        runOp("divu", DIVU, 32'd7, 32'd2);
        checkOutput("divu_loK", lo_q, 32'd3);
        checkOutput("divu_hiK", hi_q, 32'd1);
        runOp("div", DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_loK", lo_q, 32'hFFFF_FFFD);
        checkOutput("div_hiK", hi_q, 32'hFFFF_FFFF);

        // Moves and accumulate
        runOp("mthi", MTHI, 32'h1234, 32'h0);
        runOp("mtlo", MTLO, 32'h10, 32'h0);
        runOp("maddu", MADDU, 32'd2, 32'd3);
        checkOutput("maddu_hiK", hi_q, 32'h1234);
        checkOutput("maddu_loK", lo_q, 32'h16);
        runOp("msub", MSUB, 32'd1, 32'h17);
        checkOutput("msub_hiK", hi_q, 32'h1233);
        checkOutput("msub_loK", lo_q, 32'hFFFF_FFFF);

        // Divide by zero and signed overflow
        runOp("mthiAA", MTHI, 32'hAA, 32'h0);
        runOp("mtloBB", MTLO, 32'hBB, 32'h0);
        runOp("div0", DIV, 32'h1234_5678, 32'h0);
        checkOutput("div0_hiK", hi_q, 32'hAA);
        checkOutput("div0_loK", lo_q, 32'hBB);
        runOp("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf_loK", lo_q, 32'h8000_0000);
        checkOutput("divovf_hiK", hi_q, 32'h0);

        // Cancel at busy cycle 3
        applyStimulus(MULT, 32'd9, 32'd9);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("cancel3_busy", {31'h0, busy}, 32'h0);
        checkOutput("cancel3_hi", hi_q, mHi);
        checkOutput("cancel3_lo", lo_q, mLo);

        // Cancel on the commit edge
        applyStimulus(MULT, 32'd7, 32'd7);
        repeat (4) tick();
        checkOutput("cancelc_stillbusy", {31'h0, busy}, 32'h1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checkOutput("cancelc_busy", {31'h0, busy}, 32'h0);
        checkOutput("cancelc_hi", hi_q, mHi);
        checkOutput("cancelc_lo", lo_q, mLo);

        // Cancel in the same cycle as start or move
        cancel = 1'b1;
        applyStimulus(MULTU, 32'd3, 32'd3);
        checkOutput("cancels_busy", {31'h0, busy}, 32'h0);
        applyStimulus(MTLO, 32'hDEAD, 32'h0);
        cancel = 1'b0;
        tick();
        checkOutput("cancelm_lo", lo_q, mLo);

        // Reset mid-divide
        applyStimulus(DIVU, 32'd100, 32'd7);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mHi = '0;
        mLo = '0;
        checkOutput("rstmid_busy", {31'h0, busy}, 32'h0);
        checkOutput("rstmid_hi", hi_q, 32'h0);
        checkOutput("rstmid_lo", lo_q, 32'h0);

        // MTLO while busy is ignored (divide by zero leaves LO alone)
        runOp("mtlo55", MTLO, 32'h55, 32'h0);
        applyStimulus(DIV, 32'd5, 32'd0);
        tick();
        applyStimulus(MTLO, 32'hBAD0, 32'h0);
        repeat (12) tick();
        checkOutput("mtlobusy_lo", lo_q, 32'h55);

        // Back-to-back: runOp issues immediately on the first idle cycle
        runOp("b2b1", MULT, 32'd11, 32'd13);
        runOp("b2b2", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Random sequence against the model
        for (int i = 0; i < 60; i++) begin
            rop = opList[$urandom_range(0, 9)];
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            runOp($sformatf("rand%0d", i), rop, ra, rb);
            rd_hi = 1'($urandom_range(0, 1));
            #1;
            checkOutput($sformatf("rand%0d_result", i), result, rd_hi ? mHi : mLo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
